// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - round-robin arbiter with a registered grant that stays locked while its owner holds req
// Optional hold-limit preemption is built when ARB_TIMEOUT_EN is defined.
module rr_lock_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 16,
  localparam int IDW = (N > 2) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] ptr;

  // Returns {found, index}: first set bit of r scanning start, start+1, ... modulo N.
  function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] start);
    logic [IDW:0] res;
    int idx;
    res = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= N) idx = idx - N;
      if (r[idx[IDW-1:0]]) res = {1'b1, idx[IDW-1:0]};
    end
    return res;
  endfunction

  logic [N-1:0]   owner_mask;
  logic [N-1:0]   others;
  logic [IDW:0]   pick_all;
  logic [IDW:0]   pick_oth;
  logic           timeout;

  assign owner_mask = N'(1) << owner;
  assign others     = req & ~owner_mask;
  assign pick_all   = rr_pick(req, ptr);
  assign pick_oth   = rr_pick(others, ptr);

  logic           new_grant;
  logic [IDW-1:0] new_idx;
  logic           new_preempt;
  logic           go_idle;

  always_comb begin
    new_grant   = 1'b0;
    new_idx     = '0;
    new_preempt = 1'b0;
    go_idle     = 1'b0;
    case (state)
      IDLE: begin
        new_grant = pick_all[IDW];
        new_idx   = pick_all[IDW-1:0];
      end
      GRANT: begin
        if (timeout && pick_oth[IDW]) begin
          new_grant   = 1'b1;
          new_idx     = pick_oth[IDW-1:0];
          new_preempt = 1'b1;
        end else if (!req[owner]) begin
          // owner released: hand over at this same edge, or fall idle
          new_grant = pick_all[IDW];
          new_idx   = pick_all[IDW-1:0];
          go_idle   = !pick_all[IDW];
        end
      end
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HCW = $clog2(MAX_HOLD + 1);

  logic [HCW-1:0] hold_cnt;

  assign timeout = (state == GRANT) && (hold_cnt == HCW'(MAX_HOLD)) && (|others);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      preempt <= new_preempt;
      if (new_grant) begin
        hold_cnt <= HCW'(1);
      end else if (go_idle) begin
        hold_cnt <= '0;
      end else if (timeout) begin
        hold_cnt <= HCW'(1);
      end else if (state == GRANT && hold_cnt != HCW'(MAX_HOLD)) begin
        hold_cnt <= hold_cnt + HCW'(1);
      end
    end
  end
`else
  logic unused_max_hold;
  logic unused_preempt;

  assign unused_max_hold = (MAX_HOLD != 0);
  assign unused_preempt  = new_preempt;
  assign timeout         = 1'b0;
  assign preempt         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
      ptr   <= '0;
      gnt   <= '0;
    end else if (new_grant) begin
      state <= GRANT;
      owner <= new_idx;
      ptr   <= (int'(new_idx) == N - 1) ? '0 : new_idx + IDW'(1);
      gnt   <= N'(1) << new_idx;
    end else if (go_idle) begin
      state <= IDLE;
      gnt   <= '0;
    end
  end

  assign gnt_id    = owner;
  assign gnt_valid = (state == GRANT);

endmodule

// File: doc/rr_lock_arbiter.md
# rr_lock_arbiter

Parametrised round-robin arbiter with a registered, lockable grant for the multicore shared-bus and cache-port path. It supports N requesters and keeps a grant as long as its owner holds `req`. On release, it hands the grant to the next requester with no idle cycle. An optional hold-limit timer forces the owner to give up the grant when other cores are waiting.

## Interface
- `N`, default 4: number of requesters; must be ≥ 2.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles while a competitor waits; must be ≥ 1. Used only with `ARB_TIMEOUT_EN`.
- `IDW`, default max(1,$clog2(N)): width of `gnt_id`; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  request per core. Holding it high after grant keeps ownership.
- `gnt`  out  N  registered one-hot grant; all-zero when idle.
- `gnt_id`  out  IDW  binary index of the current owner; valid only when `gnt_valid`=1.
- `gnt_valid`  out  1  equals OR of `gnt`.
- `preempt`  out  1  one-cycle pulse, high in the first cycle of a grant that was taken by timeout.

## Operation
- State: `owner` (IDW bits), `busy` (FSM IDLE/GRANT), `ptr` (IDW bits, next highest priority index), `hold_cnt` (exists only with the macro).
- Search rule: scan indices `ptr`, `ptr+1`, … `ptr+N-1` modulo N. The first set `req` wins. Wrap-around past N-1 to 0 is required. Non-power-of-two N must never produce an index ≥ N.
- IDLE:
  - No `req` set: stay IDLE, `gnt`=0.
  - Otherwise: grant the winner and go to GRANT.
  - Set `owner`=winner and `ptr`=(winner+1) mod N.
- GRANT:
  - `req[owner]`=1 and not timed out: hold. `gnt` is unchanged and `ptr` is unchanged.
  - `req[owner]`=0: search from `ptr`.
    - Winner found: grant it at the same edge (back-to-back handoff).
    - No winner: return to IDLE with `gnt`=0.
  - Timeout: search from `ptr` with the owner excluded.
    - Winner found: grant it and assert `preempt`.
    - No other requester: the owner keeps the grant and `hold_cnt` restarts.
- `ptr` changes only when a new grant is issued. Reissuing to the same owner after a timeout restart does not move it.
- Requests that arrive and drop while another core owns the grant are never granted. `req` is level, not latched.

## Timing
- Reset values: `gnt`=0, `gnt_id`=0, `gnt_valid`=0, `preempt`=0, `owner`=0, `ptr`=0, `hold_cnt`=0, FSM=IDLE.
- Reset mid-grant clears everything at the next edge. The first grant after reset favours index 0.
- Grant latency: `req` sampled high at edge k makes `gnt` high after edge k (visible in cycle k+1). There is no combinational path from `req` to `gnt`.
- Release latency: `req[owner]` sampled low at edge k makes the new `gnt` (or zero) visible after edge k. At most one `gnt` bit is set in any cycle.
- Hold counter:
  - Loaded to 1 on every new grant.
  - Increments each cycle the grant is held; saturates at `MAX_HOLD`.
  - Timeout condition: `hold_cnt`==`MAX_HOLD` while another `req` bit is set.
  - So an owner holds for at most `MAX_HOLD` cycles when contended.
- `preempt` is registered, high for exactly one cycle, and aligned with the new owner's first `gnt` cycle.

## Configuration
- `ARB_TIMEOUT_EN` defined: `hold_cnt` and the timeout logic are built, and `MAX_HOLD` is enforced.
- `ARB_TIMEOUT_EN` undefined:
  - No counter is built and `preempt` is tied to 0.
  - The owner holds the grant until it drops `req`, however long that is.
  - `MAX_HOLD` is ignored.

## Test plan
All scenarios use N=4, MAX_HOLD=4.
1. Rotation:
   - Stimulus: reset, then `req`=4'b1111 held. Each owner drops its `req` for one cycle after 2 cycles of grant.
   - Response: `gnt` sequence 0001, 0010, 0100, 1000, 0001, with no zero cycle between handoffs.
2. Single requester:
   - Stimulus: `req`=4'b0100 asserted at edge k, then dropped 3 cycles later.
   - Response: `gnt`=0100, `gnt_id`=2 and `gnt_valid`=1 from cycle k+1. Then `gnt`=0 and `gnt_valid`=0 one cycle after the drop.
3. Pointer after idle:
   - Stimulus: core 2 owns, releases, and the bus goes idle. Then `req`=4'b1101.
   - Response: `gnt`=1000 (`gnt_id`=3), because `ptr`=3.
4. Timeout (macro on):
   - Stimulus: `req[0]` and `req[1]` held from reset.
   - Response: `gnt`=0001 for exactly 4 cycles, then 0010 with `preempt`=1 for one cycle. After 4 more cycles, 0001 again with `preempt`=1.
5. Uncontended hold:
   - Stimulus: only `req[0]` held for 12 cycles.
   - Response: `gnt`=0001 throughout and `preempt` stays 0. Same result with the macro off, even when `req[1]` is also held.
6. Reset mid-grant:
   - Stimulus: `rst` pulsed while `gnt`=0100, then `req`=4'b1111.
   - Response: all outputs 0 one cycle after `rst` is sampled. First grant afterwards is 0001.
